// File: rtl/reg_write_bank_pkg.sv
// cpu_rf_pkg: shared register-file constants and slice helper
package cpu_rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG = 2 ** ADDR_W;
  localparam int NBYTE = DATA_W / 8;
  localparam int CNT_W = 16;
  localparam int REG_ZERO = 0;
  function automatic int slice_lo(input int n);
    return n * DATA_W;
  endfunction
endpackage

// File: rtl/reg_write_bank_if.sv
// reg_write_bank_if: write-back, issue and register-file status signals
interface reg_write_bank_if;
  import cpu_rf_pkg::*;
  logic WE;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [NBYTE-1:0] WBE;
  logic ISSUE;
  logic [ADDR_W-1:0] ISSUE_A;
  logic [NREG*DATA_W-1:0] Q_ALL;
  logic [NREG-1:0] BUSY;
  logic WACK;
  logic [CNT_W-1:0] WCNT;
  modport master (output WE, WA, WD, WBE, ISSUE, ISSUE_A, input Q_ALL, BUSY, WACK, WCNT);
  modport slave (input WE, WA, WD, WBE, ISSUE, ISSUE_A, output Q_ALL, BUSY, WACK, WCNT);
endinterface

// File: rtl/reg_write_bank_wdec.sv
// rf_wdec: enabled one-hot register address decoder
module rf_wdec
  import cpu_rf_pkg::*;
(
  input  logic en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0] sel
);
  assign sel = en ? NREG'(1) << addr : '0;
endmodule

// File: rtl/reg_write_bank.sv
// reg_write_bank: register-file write side with byte enables and pending-write scoreboard
module reg_write_bank
  import cpu_rf_pkg::*;
(
  input logic CLK,
  input logic RST,
  reg_write_bank_if.slave bus
);
  logic [NREG-1:0] wsel, isel, busy, busy_nxt;
  logic [DATA_W-1:0] bmask;
  logic wack;
  logic [CNT_W-1:0] wcnt;
  rf_wdec u_wdec (.en(bus.WE), .addr(bus.WA), .sel(wsel));
  rf_wdec u_idec (.en(bus.ISSUE), .addr(bus.ISSUE_A), .sel(isel));
  for (genvar b = 0; b < NBYTE; b++) begin : g_mask
    assign bmask[8*b +: 8] = {8{bus.WBE[b]}};
  end
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    if (g == REG_ZERO) begin : g_zero
      assign bus.Q_ALL[slice_lo(g) +: DATA_W] = '0;
    end else begin : g_store
      logic [DATA_W-1:0] r;
      always_ff @(posedge CLK or posedge RST)
        if (RST) r <= '0;
        else if (wsel[g]) r <= (r & ~bmask) | (bus.WD & bmask);
      assign bus.Q_ALL[slice_lo(g) +: DATA_W] = r;
    end
  end
  // a new producer issued on the same edge outranks the retiring write
  assign busy_nxt = ((busy & ~wsel) | isel) & ~(NREG'(1) << REG_ZERO);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      busy <= '0;
      wack <= 1'b0;
      wcnt <= '0;
    end else begin
      busy <= busy_nxt;
      wack <= bus.WE;
      wcnt <= bus.WE ? wcnt + 1'b1 : wcnt;
    end
  assign bus.BUSY = busy;
  assign bus.WACK = wack;
  assign bus.WCNT = wcnt;
endmodule

// File: tb/tb_reg_write_bank.sv
// tb_reg_write_bank: vector table plus scoreboard checks for reg_write_bank
module tb_reg_write_bank;
  import cpu_rf_pkg::*;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  reg_write_bank_if bus();
  reg_write_bank dut (.CLK(CLK), .RST(RST), .bus(bus));

  typedef struct {
    logic [NREG*DATA_W-1:0] q;
    logic [NREG-1:0] busy;
    logic wack;
    logic [15:0] wcnt;
  } exp_t;
  typedef struct {
    logic we; logic [4:0] wa; logic [31:0] wd; logic [3:0] wbe;
    logic iss; logic [4:0] ia;
    int ra; logic [31:0] rv; int ba; logic bv;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];
  logic [31:0] m_reg[NREG];
  logic [NREG-1:0] m_busy;
  logic [15:0] m_cnt;
  logic m_wack;
  int checks = 0;
  int errors = 0;

  function automatic logic [NREG*DATA_W-1:0] m_flat();
    logic [NREG*DATA_W-1:0] f;
    for (int n = 0; n < NREG; n++) f[n*DATA_W +: DATA_W] = m_reg[n];
    return f;
  endfunction

  function automatic logic [31:0] dreg(input int n);
    return bus.Q_ALL[n*DATA_W +: DATA_W];
  endfunction

  task automatic m_reset();
    for (int n = 0; n < NREG; n++) m_reg[n] = '0;
    m_busy = '0;
    m_cnt = '0;
    m_wack = 1'b0;
    sb.delete();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_q(input string name, input logic [NREG*DATA_W-1:0] act, input logic [NREG*DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int n = 0; n < NREG; n++)
        if (act[n*DATA_W +: DATA_W] !== exp[n*DATA_W +: DATA_W]) begin
          $display("FAIL %s reg%0d got %h want %h", name, n, act[n*DATA_W +: DATA_W], exp[n*DATA_W +: DATA_W]);
          break;
        end
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] wbe, input logic iss, input logic [4:0] ia);
    exp_t e;
    bus.WE = we; bus.WA = wa; bus.WD = wd; bus.WBE = wbe; bus.ISSUE = iss; bus.ISSUE_A = ia;
    if (we && wa != 0)
      for (int i = 0; i < 4; i++) if (wbe[i]) m_reg[wa][8*i +: 8] = wd[8*i +: 8];
    if (we) m_busy[wa] = 1'b0;
    if (iss && ia != 0) m_busy[ia] = 1'b1;
    m_wack = we;
    if (we) m_cnt++;
    e.q = m_flat(); e.busy = m_busy; e.wack = m_wack; e.wcnt = m_cnt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk_q("q_all", bus.Q_ALL, e.q);
    chk("busy", 64'(bus.BUSY), 64'(e.busy));
    chk("wack", 64'(bus.WACK), 64'(e.wack));
    chk("wcnt", 64'(bus.WCNT), 64'(e.wcnt));
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd7, 32'h11223344, 4'hF, 1'b0, 5'd0, 7, 32'h11223344, 7, 1'b0};
    vt[1] = '{1'b1, 5'd7, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 7, 32'h11BB33DD, 7, 1'b0};
    vt[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd0, 0, 32'h0, 0, 1'b0};
    vt[3] = '{1'b1, 5'd9, 32'h12345678, 4'hF, 1'b1, 5'd9, 9, 32'h12345678, 9, 1'b1};
    vt[4] = '{1'b1, 5'd9, 32'h00000000, 4'h0, 1'b0, 5'd0, 9, 32'h12345678, 9, 1'b0};
    vt[5] = '{1'b1, 5'd4, 32'h00000044, 4'hF, 1'b1, 5'd3, 4, 32'h00000044, 3, 1'b1};
    vt[6] = '{1'b0, 5'd3, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd3, 3, 32'h0, 3, 1'b1};
    vt[7] = '{1'b1, 5'd3, 32'hCAFEF00D, 4'b1000, 1'b0, 5'd0, 3, 32'hCA000000, 3, 1'b0};
    vt[8] = '{1'b0, 5'd1, 32'h55555555, 4'hF, 1'b1, 5'd12, 1, 32'h0, 12, 1'b1};
    m_reset();
    bus.WE = 0; bus.WA = 0; bus.WD = 0; bus.WBE = 0; bus.ISSUE = 0; bus.ISSUE_A = 0;
    #12;
    chk_q("rst_q", bus.Q_ALL, '0);
    chk("rst_busy", 64'(bus.BUSY), 64'd0);
    chk("rst_wack", 64'(bus.WACK), 64'd0);
    chk("rst_wcnt", 64'(bus.WCNT), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    for (int v = 0; v < 9; v++) begin
      drive(vt[v].we, vt[v].wa, vt[v].wd, vt[v].wbe, vt[v].iss, vt[v].ia);
      chk($sformatf("vec%0d_reg", v), 64'(dreg(vt[v].ra)), 64'(vt[v].rv));
      chk($sformatf("vec%0d_busy", v), 64'(bus.BUSY[vt[v].ba]), 64'(vt[v].bv));
      if (v == 2) chk("zero_wcnt", 64'(bus.WCNT), 64'd3);
    end
    // reset lands between edges while a write is held on the bus
    @(negedge CLK);
    bus.WE = 1; bus.WA = 5; bus.WD = 32'hDEADBEEF; bus.WBE = 4'hF; bus.ISSUE = 0;
    #2 RST = 1'b1;
    #1;
    chk_q("midrst_q", bus.Q_ALL, '0);
    chk("midrst_busy", 64'(bus.BUSY), 64'd0);
    chk("midrst_wcnt", 64'(bus.WCNT), 64'd0);
    #1 RST = 1'b0;
    m_reset();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0);
    chk("postrst_reg5", 64'(dreg(5)), 64'hDEADBEEF);
    RST = 1'b1;
    #1 RST = 1'b0;
    m_reset();
    for (int n = 1; n < NREG; n++) drive(1'b1, 5'(n), n * 32'h01010101, 4'hF, 1'b0, 5'd0);
    for (int n = 0; n < NREG; n++) chk($sformatf("sweep_reg%0d", n), 64'(dreg(n)), 64'(n * 32'h01010101));
    chk("sweep_wcnt", 64'(bus.WCNT), 64'd31);
    bus.WE = 1; bus.WA = 0; bus.WBE = 4'hF; bus.ISSUE = 0;
    repeat (65504) @(posedge CLK);
    m_cnt = 16'hFFFF;
    m_wack = 1'b1;
    #1;
    chk("pre_wrap_wcnt", 64'(bus.WCNT), 64'hFFFF);
    drive(1'b1, 5'd0, 32'h0, 4'hF, 1'b0, 5'd0);
    chk("wrap_wcnt", 64'(bus.WCNT), 64'd0);
    chk("wrap_wack", 64'(bus.WACK), 64'd1);
    drive(1'b0, 5'd6, 32'h77777777, 4'hF, 1'b0, 5'd0);
    chk("idle_wack", 64'(bus.WACK), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
